imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/cpu_defs_pkg.sv | 33 +++
 rtl/imem_array.sv | 51 +++++
 rtl/imem_loader.sv | 125 ++++++++++++
 tb/tb_imem_loader.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs_pkg.sv
// ---------------------------------------------------------------------------
// cpu_defs
// Shared definitions for the small teaching CPU and its instruction loader.
//   - loaderState_t : states of the instruction-memory loader FSM
//   - DEPTH_DEFAULT : default number of 8-bit instruction words
//   - COUNT_W       : width of the loader byte counter
//   - opcode_t      : 2-bit opcode field held in instr[7:6]
//   - opcodeOf()    : extracts the opcode field from an instruction byte
// ---------------------------------------------------------------------------
package cpu_defs;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_DONE = 2'b10
    } loaderState_t;

    localparam int DEPTH_DEFAULT = 32;
    localparam int COUNT_W       = 6;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_LW  = 2'b01,
        OP_SW  = 2'b10,
        OP_JMP = 2'b11
    } opcode_t;

    // The opcode sits in the two most significant bits of every instruction.
    function automatic opcode_t opcodeOf(input logic [7:0] instr);
        return opcode_t'(instr[7:6]);
    endfunction

endpackage

// File: rtl/imem_array.sv
// ---------------------------------------------------------------------------
// imem_array
// Instruction storage: DEPTH x 8-bit words with one synchronous write port
// (plus a whole-array clear) and one combinational read port.
// Ports:
//   clk      - clock, all writes on the rising edge
//   clear_i  - zero every word at the next edge (wins over we_i)
//   we_i     - write wdata_i into word waddr_i at the next edge
//   waddr_i  - write index
//   wdata_i  - write data
//   raddr_i  - CPU fetch address
//   rdata_o  - fetch data, 8'h00 for addresses at or beyond DEPTH
// ---------------------------------------------------------------------------
module imem_array #(
    parameter int DEPTH = 32,
    parameter int AW    = 8,
    parameter int IW    = 5
) (
    input  logic          clk,
    input  logic          clear_i,
    input  logic          we_i,
    input  logic [IW-1:0] waddr_i,
    input  logic [7:0]    wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [7:0]    rdata_o
);

    logic [7:0]  mem_q [DEPTH];
    logic [31:0] raddrWide;
    logic        raddrInRange;

    // Clear takes priority so that a reset or a fresh load always starts
    // from an all-zero program image, even if a write is requested alongside.
    always_ff @(posedge clk) begin
        if (clear_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // The read is purely combinational off the registered array, so a word
    // being written this cycle still shows its old contents until the edge.
    // Out-of-range addresses return zero instead of aliasing onto low words.
    assign raddrWide    = 32'(raddr_i);
    assign raddrInRange = (raddrWide < 32'(DEPTH));
    assign rdata_o      = raddrInRange ? mem_q[raddrWide[IW-1:0]] : 8'h00;

endmodule

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
// Streams a program into instruction memory over a valid/ready byte
// interface while holding the CPU, then lets the CPU fetch from it.
// Ports:
//   clk, reset     - clock and synchronous active-high reset
//   load_start     - one-cycle request to begin a load (ignored mid-load)
//   load_valid     - load_data carries a byte
//   load_data      - instruction byte
//   load_last      - marks the final byte of the load
//   load_ready     - a byte is accepted this cycle (state is LOAD)
//   Read_Address   - CPU fetch address
//   instruction    - combinational fetch data
//   cpu_hold       - CPU must stall its PC while a load is in progress
//   load_done      - sticky: the last load finished
//   load_error     - sticky: the last load ran past DEPTH without load_last
//   load_count     - bytes written by the current or last load
// ---------------------------------------------------------------------------
module imem_loader
    import cpu_defs::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int AW    = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_start,
    input  logic               load_valid,
    input  logic [7:0]         load_data,
    input  logic               load_last,
    output logic               load_ready,
    input  logic [AW-1:0]      Read_Address,
    output logic [7:0]         instruction,
    output logic               cpu_hold,
    output logic               load_done,
    output logic               load_error,
    output logic [COUNT_W-1:0] load_count
);

    localparam int                 IW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [COUNT_W-1:0] DEPTH_C  = COUNT_W'(DEPTH);
    localparam logic [COUNT_W-1:0] LAST_IDX = COUNT_W'(DEPTH - 1);

    loaderState_t       state_q, state_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               done_q, done_d;
    logic               error_q, error_d;

    logic               inLoad;
    logic               startLoad;
    logic               acceptByte;
    logic               memClear;

    assign inLoad     = (state_q == ST_LOAD);
    assign startLoad  = load_start && !inLoad;
    assign acceptByte = inLoad && load_valid && (count_q != DEPTH_C);

    // Next-state logic. A start request only counts from IDLE or DONE; in
    // LOAD every accepted byte bumps the counter, and either load_last or
    // filling the final word ends the load. Running into the final word
    // without load_last is the overflow case and raises the error flag.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        done_d  = done_q;
        error_d = error_q;
        if (startLoad) begin
            state_d = ST_LOAD;
            count_d = '0;
            done_d  = 1'b0;
            error_d = 1'b0;
        end else if (acceptByte) begin
            count_d = count_q + 1'b1;
            if (load_last) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
            end else if (count_q == LAST_IDX) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
                error_d = 1'b1;
            end
        end
    end

    // State register. Reset is checked first so it beats a start request or
    // a byte handshake arriving in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    // The memory image is wiped both on reset and at the start of every load,
    // so words a load never reaches read back as zero.
    assign memClear = reset || startLoad;

    imem_array #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .IW    (IW)
    ) u_array (
        .clk     (clk),
        .clear_i (memClear),
        .we_i    (acceptByte && !reset),
        .waddr_i (count_q[IW-1:0]),
        .wdata_i (load_data),
        .raddr_i (Read_Address),
        .rdata_o (instruction)
    );

    assign load_ready = inLoad;
    assign cpu_hold   = inLoad;
    assign load_done  = done_q;
    assign load_error = error_q;
    assign load_count = count_q;

endmodule

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader
// Directed sequence with random payload bytes, checked against a reference
// model of the loader kept as a plain array plus counters.
// ---------------------------------------------------------------------------
module tb_imem_loader;

    localparam int DEPTH = 32;
    localparam int AW    = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             load_start;
    logic             load_valid;
    logic [7:0]       load_data;
    logic             load_last;
    logic             load_ready;
    logic [AW-1:0]    Read_Address;
    logic [7:0]       instruction;
    logic             cpu_hold;
    logic             load_done;
    logic             load_error;
    logic [5:0]       load_count;

    always #5 clk = ~clk;

    imem_loader #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .load_start   (load_start),
        .load_valid   (load_valid),
        .load_data    (load_data),
        .load_last    (load_last),
        .load_ready   (load_ready),
        .Read_Address (Read_Address),
        .instruction  (instruction),
        .cpu_hold     (cpu_hold),
        .load_done    (load_done),
        .load_error   (load_error),
        .load_count   (load_count)
    );

    // Reference model: the program image, how many bytes the current load
    // has stored, and whether a load is still open.
    logic [7:0] refMem [DEPTH];
    int         refCount;
    bit         refLoading;
    bit         refDone;
    bit         refErr;

    int passCount  = 0;
    int checkCount = 0;

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic modelEdge();
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) refMem[i] = 8'h00;
            refCount   = 0;
            refLoading = 0;
            refDone    = 0;
            refErr     = 0;
        end else if (!refLoading && load_start) begin
            for (int i = 0; i < DEPTH; i++) refMem[i] = 8'h00;
            refCount   = 0;
            refLoading = 1;
            refDone    = 0;
            refErr     = 0;
        end else if (refLoading && load_valid) begin
            refMem[refCount] = load_data;
            refCount++;
            if (load_last) begin
                refLoading = 0;
                refDone    = 1;
            end else if (refCount == DEPTH) begin
                refLoading = 0;
                refDone    = 1;
                refErr     = 1;
            end
        end
    endtask

    // One clock with the currently driven inputs; returns 1 time unit after
    // the rising edge so outputs are sampled away from the edge.
    task automatic applyStimulus();
        modelEdge();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic sendByte(input logic [7:0] d, input logic last);
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        applyStimulus();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic pulseStart();
        load_start = 1'b1;
        applyStimulus();
        load_start = 1'b0;
    endtask

    task automatic checkStatus(input string tag);
        checkOutput({tag, "_ready"}, 32'(load_ready), 32'(refLoading));
        checkOutput({tag, "_hold"},  32'(cpu_hold),   32'(refLoading));
        checkOutput({tag, "_done"},  32'(load_done),  32'(refDone));
        checkOutput({tag, "_error"}, 32'(load_error), 32'(refErr));
        checkOutput({tag, "_count"}, 32'(load_count), 32'(refCount));
    endtask

    // Walks every address; control inputs are idle so nothing changes.
    task automatic checkMemory(input string tag);
        for (int a = 0; a < DEPTH; a++) begin
            Read_Address = AW'(a);
            #1;
            checkOutput($sformatf("%s_mem%0d", tag, a), 32'(instruction),
                        32'(refMem[a]));
        end
    endtask

    initial begin
        logic [7:0] b;
        int         sent;

        reset        = 1'b1;
        load_start   = 1'b0;
        load_valid   = 1'b0;
        load_data    = 8'h00;
        load_last    = 1'b0;
        Read_Address = '0;

        // Reset
        applyStimulus();
        applyStimulus();
        reset = 1'b0;
        checkStatus("reset");
        checkMemory("reset");

        // Three-byte program with load_last on the final byte
        pulseStart();
        checkStatus("start3");
        sendByte(8'h65, 1'b0);
        sendByte(8'h84, 1'b0);
        sendByte(8'h58, 1'b1);
        checkStatus("prog3");
        checkOutput("prog3_count_lit", 32'(load_count), 32'd3);
        Read_Address = 8'd0; #1;
        checkOutput("prog3_addr0", 32'(instruction), 32'h65);
        Read_Address = 8'd1; #1;
        checkOutput("prog3_addr1", 32'(instruction), 32'h84);
        Read_Address = 8'd2; #1;
        checkOutput("prog3_addr2", 32'(instruction), 32'h58);
        Read_Address = 8'd3; #1;
        checkOutput("prog3_addr3", 32'(instruction), 32'h00);

        // Valid outside LOAD is ignored
        sendByte(8'hC3, 1'b1);
        checkStatus("idlevalid");
        checkMemory("idlevalid");

        // Overflow: DEPTH bytes without load_last
        pulseStart();
        for (int i = 0; i < DEPTH; i++) begin
            sendByte(8'($urandom_range(0, 255)), 1'b0);
        end
        checkStatus("ovf");
        checkOutput("ovf_error_lit", 32'(load_error), 32'd1);
        checkOutput("ovf_count_lit", 32'(load_count), 32'(DEPTH));
        load_valid = 1'b1;
        load_data  = 8'hEE;
        #1;
        checkOutput("ovf_extra_ready", 32'(load_ready), 32'd0);
        applyStimulus();
        load_valid = 1'b0;
        checkStatus("ovf_extra");
        checkMemory("ovf");

        // Full image with load_last on the final word: no error
        pulseStart();
        for (int i = 0; i < DEPTH; i++) begin
            sendByte(8'($urandom_range(0, 255)), (i == DEPTH - 1));
        end
        checkStatus("full");
        checkMemory("full");

        // Gapped stream: only handshaked bytes land, hold stays high
        pulseStart();
        sent = 0;
        while (sent < 10) begin
            if ($urandom_range(0, 2) == 0) begin
                load_data = 8'($urandom_range(0, 255));
                applyStimulus();
            end else begin
                sendByte(8'($urandom_range(0, 255)), (sent == 9));
                sent++;
            end
            if (sent < 10) checkOutput("gap_hold", 32'(cpu_hold), 32'd1);
        end
        checkStatus("gap");
        checkMemory("gap");

        // Read-during-write on index 5
        pulseStart();
        for (int i = 0; i < 5; i++) sendByte(8'($urandom_range(0, 255)), 1'b0);
        Read_Address = 8'd5;
        load_valid   = 1'b1;
        load_data    = 8'h3A;
        load_last    = 1'b0;
        #1;
        checkOutput("rdw_old", 32'(instruction), 32'(refMem[5]));
        applyStimulus();
        load_valid = 1'b0;
        checkOutput("rdw_new", 32'(instruction), 32'h3A);

        // load_start mid-load is ignored, even alongside a byte
        load_start = 1'b1;
        load_valid = 1'b1;
        b          = 8'($urandom_range(0, 255));
        load_data  = b;
        applyStimulus();
        load_start = 1'b0;
        load_valid = 1'b0;
        checkStatus("midstart");
        checkOutput("midstart_count_lit", 32'(load_count), 32'd7);
        Read_Address = 8'h40; #1;
        checkOutput("oor_40", 32'(instruction), 32'h00);
        Read_Address = 8'h20; #1;
        checkOutput("oor_20", 32'(instruction), 32'h00);
        Read_Address = 8'hFF; #1;
        checkOutput("oor_ff", 32'(instruction), 32'h00);
        checkMemory("midstart");

        // Reset aborts a load after 4 of 10 bytes; reset also beats a byte
        pulseStart();
        for (int i = 0; i < 4; i++) sendByte(8'($urandom_range(1, 255)), 1'b0);
        reset      = 1'b1;
        load_valid = 1'b1;
        load_start = 1'b1;
        load_data  = 8'h99;
        applyStimulus();
        reset      = 1'b0;
        load_valid = 1'b0;
        load_start = 1'b0;
        checkStatus("abort");
        checkOutput("abort_done_lit", 32'(load_done), 32'd0);
        checkMemory("abort");

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
